// File: rtl/vga_text_controller.sv
// Raster timing generator and text-mode fetch sequencer: drives the text-RAM address at S0,
// the glyph row at S1, and the glyph column, syncs, visibility and cursor at S2 (ROM-aligned).
module vga_text_controller #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned COLS      = 80,
  parameter int unsigned ROWS      = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cursor_en,
  input  logic [6:0]  cursor_col,
  input  logic [4:0]  cursor_row,
  output logic [11:0] TextA,
  output logic [3:0]  row,
  output logic [2:0]  col,
  output logic        hsync,
  output logic        vsync,
  output logic        von,
  output logic        cursor_hit,
  output logic        frame_tick
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [6:0] COLS_LIM = 7'(COLS);
  localparam logic [5:0] ROWS_LIM = 6'(ROWS);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic [4:0] fcnt;
  logic       wrap;

  logic       vis0;
  logic       hs0;
  logic       vs0;
  logic       cur0;
  logic [5:0] char_r;
  logic [6:0] char_c;

  logic [2:0] col1;
  logic       hs1;
  logic       vs1;
  logic       vis1;
  logic       cur1;

  assign wrap = (h_cnt == H_LAST) && (v_cnt == V_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // Registered wrap detect lands the tick on the (0,0) cycle; the reset frame never wraps into it.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_tick <= 1'b0;
      fcnt       <= '0;
    end else begin
      frame_tick <= wrap;
      if (frame_tick) fcnt <= fcnt + 5'd1;
    end
  end

  always_comb begin
    char_r = v_cnt[9:4];
    char_c = h_cnt[9:3];
    vis0   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    hs0    = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    vs0    = !((v_cnt >= VS_START) && (v_cnt < VS_END));
    TextA  = '0;
    if (vis0)
      TextA = {char_r, 6'b0} + {2'b0, char_r, 4'b0} + {5'b0, char_c};
    cur0 = cursor_en && vis0 && fcnt[4]
        && (cursor_col < COLS_LIM) && ({1'b0, cursor_row} < ROWS_LIM)
        && (char_c == cursor_col) && (char_r == {1'b0, cursor_row})
        && (v_cnt[3:0] >= 4'd14);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row        <= '0;
      col1       <= '0;
      hs1        <= 1'b1;
      vs1        <= 1'b1;
      vis1       <= 1'b0;
      cur1       <= 1'b0;
      col        <= '0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      von        <= 1'b0;
      cursor_hit <= 1'b0;
    end else begin
      row        <= v_cnt[3:0];
      col1       <= h_cnt[2:0];
      hs1        <= hs0;
      vs1        <= vs0;
      vis1       <= vis0;
      cur1       <= cur0;
      col        <= col1;
      hsync      <= hs1;
      vsync      <= vs1;
      von        <= vis1;
      cursor_hit <= cur1;
    end
  end

endmodule

// File: tb/tb_vga_text_controller.sv
// Directed checks on a full-size 640x480 instance and a reduced-timing instance (80x35 raster)
// that makes frame ticks and the cursor blink phase reachable in a short run.
module tb_vga_text_controller;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, srst;
  logic        cen, scen;
  logic [6:0]  ccol, sccol;
  logic [4:0]  crow, scrow;

  logic [11:0] d_texta, s_texta;
  logic [3:0]  d_row, s_row;
  logic [2:0]  d_col, s_col;
  logic        d_hs, d_vs, d_von, d_hit, d_ft;
  logic        s_hs, s_vs, s_von, s_hit, s_ft;

  int unsigned cyc;
  int unsigned checks;
  int unsigned errors;

  vga_text_controller dut (
    .clk(clk), .rst(rst), .cursor_en(cen), .cursor_col(ccol), .cursor_row(crow),
    .TextA(d_texta), .row(d_row), .col(d_col), .hsync(d_hs), .vsync(d_vs),
    .von(d_von), .cursor_hit(d_hit), .frame_tick(d_ft)
  );

  vga_text_controller #(
    .H_VISIBLE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_VISIBLE(32), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .COLS(8), .ROWS(2)
  ) sdut (
    .clk(clk), .rst(srst), .cursor_en(scen), .cursor_col(sccol), .cursor_row(scrow),
    .TextA(s_texta), .row(s_row), .col(s_col), .hsync(s_hs), .vsync(s_vs),
    .von(s_von), .cursor_hit(s_hit), .frame_tick(s_ft)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go(input int unsigned target);
    while (cyc < target) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  initial begin
    cyc = 0; checks = 0; errors = 0;
    rst = 1'b1; srst = 1'b1;
    cen = 1'b1; ccol = 7'd5; crow = 5'd2;
    scen = 1'b1; sccol = 7'd5; scrow = 5'd1;
    tick(); tick();
    rst = 1'b0; srst = 1'b0;
    cyc = 0;

    chk("rst_texta", 32'(d_texta), 0);
    chk("rst_row", 32'(d_row), 0);
    chk("rst_col", 32'(d_col), 0);
    chk("rst_hsync", 32'(d_hs), 1);
    chk("rst_vsync", 32'(d_vs), 1);
    chk("rst_von", 32'(d_von), 0);
    chk("rst_hit", 32'(d_hit), 0);
    chk("rst_ftick", 32'(d_ft), 0);
    chk("s_rst_ftick", 32'(s_ft), 0);

    go(69);    chk("s_hs_pre", 32'(s_hs), 1);
    go(70);    chk("s_hs_fall", 32'(s_hs), 0);
    go(77);    chk("s_hs_last", 32'(s_hs), 0);
    go(78);    chk("s_hs_rise", 32'(s_hs), 1);
    go(639);   chk("texta_639_0", 32'(d_texta), 79);
    go(640);   chk("texta_640_0", 32'(d_texta), 0);
    go(641);   chk("von_639", 32'(d_von), 1);
    go(642);   chk("von_640", 32'(d_von), 0);
    go(657);   chk("hs_pre", 32'(d_hs), 1);
    go(658);   chk("hs_fall", 32'(d_hs), 0);
    go(753);   chk("hs_last", 32'(d_hs), 0);
    go(754);   chk("hs_rise", 32'(d_hs), 1);
    go(1458);  chk("hs_line1", 32'(d_hs), 0);
    go(2543);  chk("s_texta_last", 32'(s_texta), 87);
    go(2544);  chk("s_texta_blank", 32'(s_texta), 0);
    go(2641);  chk("s_vs_pre", 32'(s_vs), 1);
    go(2642);  chk("s_vs_fall", 32'(s_vs), 0);
    go(2721);  chk("s_vs_last", 32'(s_vs), 0);
    go(2722);  chk("s_vs_rise", 32'(s_vs), 1);
    go(2799);  chk("s_ft_pre", 32'(s_ft), 0);
    go(2800);  chk("s_ft_1", 32'(s_ft), 1);
    go(2801);  chk("s_ft_post", 32'(s_ft), 0);
    go(5599);  chk("s_ft_pre2", 32'(s_ft), 0);
    go(5600);  chk("s_ft_2", 32'(s_ft), 1);

    go(28017); chk("texta_17_35", 32'(d_texta), 162);
    go(28018); chk("row_35", 32'(d_row), 3);
    go(28019); chk("col_17", 32'(d_col), 1);
               chk("von_17_35", 32'(d_von), 1);
    go(36842); chk("hit_phase0", 32'(d_hit), 0);

    // Mid-frame reset of the full-size instance at (300,46)
    go(37100); chk("von_before_rst", 32'(d_von), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_h", 32'(dut.h_cnt), 0);
    chk("mrst_v", 32'(dut.v_cnt), 0);
    chk("mrst_fcnt", 32'(dut.fcnt), 0);
    chk("mrst_hs0", 32'(d_hs), 1);
    chk("mrst_von0", 32'(d_von), 0);
    tick();
    chk("mrst_h1", 32'(dut.h_cnt), 1);
    chk("mrst_hs1", 32'(d_hs), 1);
    chk("mrst_vs1", 32'(d_vs), 1);
    chk("mrst_von1", 32'(d_von), 0);
    tick();
    chk("mrst_von2", 32'(d_von), 1);
    chk("mrst_col2", 32'(d_col), 0);
    tick();
    chk("mrst_col3", 32'(d_col), 1);
    go(37758); chk("mrst_hs_pre", 32'(d_hs), 1);
    go(37759); chk("mrst_hs_fall", 32'(d_hs), 0);

    go(44442); chk("s_hit_frame15", 32'(s_hit), 0);
    go(44800); chk("s_fcnt_15", 32'(sdut.fcnt), 15);
    go(44801); chk("s_fcnt_16", 32'(sdut.fcnt), 16);
    go(47241); chk("s_hit_left", 32'(s_hit), 0);
    go(47242); chk("s_hit_start", 32'(s_hit), 1);
    go(47249); chk("s_hit_end", 32'(s_hit), 1);
    go(47250); chk("s_hit_right", 32'(s_hit), 0);
    go(47322); chk("s_hit_l31_start", 32'(s_hit), 1);
    go(47329); chk("s_hit_l31_end", 32'(s_hit), 1);

    go(47600); sccol = 7'd8;
    go(50042); chk("s_hit_col_oor", 32'(s_hit), 0);
    go(50400); sccol = 7'd5; scen = 1'b0;
    go(52842); chk("s_hit_disabled", 32'(s_hit), 0);
    go(53200); scen = 1'b1;
    go(55642); chk("s_hit_restored", 32'(s_hit), 1);
    go(55999); chk("s_ft_pre20", 32'(s_ft), 0);
    go(56000); chk("s_ft_20", 32'(s_ft), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
